vel_estimator: RTL and testbench

Recovers global velocities (VX, VY, WZ) from the robot pose (POSX, POSY, THETA) by finite differencing: pose is sampled every 10 ms, the previous sample is subtracted, and the delta is scaled by 1/dt = 100. It sits on the odometry path as the inverse of the pose integrator, closing the loop for velocity-feedback checks and telemetry. Arithmetic is 17b sign-magnitude Q8, the same format as the pose buses. One shared sequential shift-add multiplier serves all three axes.

---
 rtl/vel_estimator_pkg.sv | 23 ++
 rtl/vel_estimator_sm_subtract.sv | 43 ++++
 rtl/vel_estimator.sv | 187 ++++++++++++++++++
 tb/tb_vel_estimator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vel_estimator_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vel_estimator_pkg -- shared types and constants for vel_estimator
// Revision : 1.0
// ============================================================================
package vel_estimator_pkg;

    localparam int          DEF_TICK_COUNT = 500000;
    localparam int          DEF_GAIN       = 100;
    localparam int          SM_SIGN        = 16;
    localparam logic [15:0] SM_MAG_MAX     = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_DIFF    = 3'd2,
        ST_MULT    = 3'd3,
        ST_STORE   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vel_estimator_sm_subtract.sv
`default_nettype none
// ============================================================================
// Module   : sm_subtract -- combinational sign-magnitude a-b, saturating
// Revision : 1.0
// ============================================================================
module sm_subtract
    import vel_estimator_pkg::*;
(
    input  logic [SM_SIGN:0] i_a,
    input  logic [SM_SIGN:0] i_b,
    output logic [SM_SIGN:0] o_y
);

    logic [SM_SIGN-1:0] w_a_mag;
    logic [SM_SIGN-1:0] w_b_mag;
    logic [SM_SIGN-1:0] w_mag;
    logic [SM_SIGN:0]   w_sum;
    logic               w_sign;

    assign w_a_mag = i_a[SM_SIGN-1:0];
    assign w_b_mag = i_b[SM_SIGN-1:0];
    assign w_sum   = {1'b0, w_a_mag} + {1'b0, w_b_mag};

    // a-b is a + (-b): opposite signs add magnitudes, equal signs subtract
    always_comb begin
        w_mag  = '0;
        w_sign = 1'b0;
        if (i_a[SM_SIGN] != i_b[SM_SIGN]) begin
            w_mag  = w_sum[SM_SIGN] ? SM_MAG_MAX : w_sum[SM_SIGN-1:0];
            w_sign = i_a[SM_SIGN];
        end else if (w_a_mag >= w_b_mag) begin
            w_mag  = w_a_mag - w_b_mag;
            w_sign = i_a[SM_SIGN];
        end else begin
            w_mag  = w_b_mag - w_a_mag;
            w_sign = ~i_b[SM_SIGN];
        end
    end

    assign o_y = {w_sign & (|w_mag), w_mag};

endmodule
`default_nettype wire

// File: rtl/vel_estimator.sv
`default_nettype none
// ============================================================================
// Module   : vel_estimator -- pose finite-difference velocity, shared multiplier
// Revision : 1.0
// ============================================================================
module vel_estimator
    import vel_estimator_pkg::*;
#(
    parameter int N_WIDTH    = 17,
    parameter int Q_WIDTH    = 8,
    parameter int TICK_COUNT = DEF_TICK_COUNT,
    parameter int GAIN       = DEF_GAIN
) (
    input  logic               VEL_ESTIMATOR_CLOCK_50,
    input  logic               VEL_ESTIMATOR_RESET_InLow,
    input  logic               VEL_ESTIMATOR_SETBEGIN_InLow,
    input  logic [N_WIDTH-1:0] VEL_ESTIMATOR_POSX_InBus,
    input  logic [N_WIDTH-1:0] VEL_ESTIMATOR_POSY_InBus,
    input  logic [N_WIDTH-1:0] VEL_ESTIMATOR_THETA_InBus,
    output logic [N_WIDTH-1:0] VEL_ESTIMATOR_VX_OutBus,
    output logic [N_WIDTH-1:0] VEL_ESTIMATOR_VY_OutBus,
    output logic [N_WIDTH-1:0] VEL_ESTIMATOR_WZ_OutBus,
    output logic               VEL_ESTIMATOR_VALID_Out,
    output logic               VEL_ESTIMATOR_OVERRUN_Out
);

    localparam int              MAG_W       = N_WIDTH - 1;
    localparam int              ACC_W       = MAG_W + 7;
    localparam int              CNT_W       = $clog2(TICK_COUNT);
    localparam logic [6:0]      C_GAIN      = 7'(GAIN);
    localparam logic [CNT_W-1:0] C_TICK_LAST = CNT_W'(TICK_COUNT - 1);

    generate
        if (Q_WIDTH >= MAG_W) begin : g_bad_q_width
            $error("Q_WIDTH leaves no integer magnitude bits");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_primed;
    logic [1:0]         r_axis;
    logic [2:0]         r_bit;
    logic [N_WIDTH-1:0] r_cur_x, r_cur_y, r_cur_t;
    logic [N_WIDTH-1:0] r_prev_x, r_prev_y, r_prev_t;
    logic [N_WIDTH-1:0] r_stage_x, r_stage_y, r_stage_t;
    logic [N_WIDTH-1:0] r_delta;
    logic [ACC_W-1:0]   r_acc;
    logic [N_WIDTH-1:0] r_vx, r_vy, r_wz;
    logic               r_valid, r_overrun;

    logic               w_tick;
    logic               w_idle, w_capture, w_diff, w_mult, w_store, w_done;
    logic [N_WIDTH-1:0] w_cur_sel, w_prev_sel, w_delta;
    logic [MAG_W-1:0]   w_mag;
    logic               w_sign;

    assign w_tick = (r_cnt == C_TICK_LAST);

    always_comb begin
        w_cur_sel  = r_cur_t;
        w_prev_sel = r_prev_t;
        case (r_axis)
            2'd0: begin w_cur_sel = r_cur_x; w_prev_sel = r_prev_x; end
            2'd1: begin w_cur_sel = r_cur_y; w_prev_sel = r_prev_y; end
            default: ;
        endcase
    end

    sm_subtract u_sub (
        .i_a (w_cur_sel),
        .i_b (w_prev_sel),
        .o_y (w_delta)
    );

    // Saturate the product; a zero result is always +0
    assign w_mag  = (|r_acc[ACC_W-1:MAG_W]) ? MAG_W'(SM_MAG_MAX) : r_acc[MAG_W-1:0];
    assign w_sign = r_delta[SM_SIGN] & (|w_mag);

    always_ff @(posedge VEL_ESTIMATOR_CLOCK_50 or negedge VEL_ESTIMATOR_RESET_InLow) begin
        if (!VEL_ESTIMATOR_RESET_InLow)
            r_state <= ST_IDLE;
        else if (!VEL_ESTIMATOR_SETBEGIN_InLow)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_tick) w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = r_primed ? ST_DIFF : ST_IDLE;
            ST_DIFF:    w_next = ST_MULT;
            ST_MULT:    if (r_bit == 3'd6) w_next = ST_STORE;
            ST_STORE:   w_next = (r_axis == 2'd2) ? ST_DONE : ST_DIFF;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_idle    = (r_state == ST_IDLE);
        w_capture = (r_state == ST_CAPTURE);
        w_diff    = (r_state == ST_DIFF);
        w_mult    = (r_state == ST_MULT);
        w_store   = (r_state == ST_STORE);
        w_done    = (r_state == ST_DONE);
    end

    always_ff @(posedge VEL_ESTIMATOR_CLOCK_50 or negedge VEL_ESTIMATOR_RESET_InLow) begin
        if (!VEL_ESTIMATOR_RESET_InLow) begin
            r_cnt     <= '0;
            r_primed  <= 1'b0;
            r_axis    <= '0;
            r_bit     <= '0;
            r_cur_x   <= '0; r_cur_y   <= '0; r_cur_t   <= '0;
            r_prev_x  <= '0; r_prev_y  <= '0; r_prev_t  <= '0;
            r_stage_x <= '0; r_stage_y <= '0; r_stage_t <= '0;
            r_delta   <= '0;
            r_acc     <= '0;
            r_vx      <= '0; r_vy      <= '0; r_wz      <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!VEL_ESTIMATOR_SETBEGIN_InLow) begin
            r_cnt     <= '0;
            r_primed  <= 1'b0;
            r_vx      <= '0; r_vy      <= '0; r_wz      <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + CNT_W'(1);
            r_valid <= 1'b0;
            if (w_tick && !w_idle)
                r_overrun <= 1'b1;
            if (w_capture) begin
                r_cur_x <= VEL_ESTIMATOR_POSX_InBus;
                r_cur_y <= VEL_ESTIMATOR_POSY_InBus;
                r_cur_t <= VEL_ESTIMATOR_THETA_InBus;
                r_axis  <= 2'd0;
                if (!r_primed) begin
                    r_prev_x <= VEL_ESTIMATOR_POSX_InBus;
                    r_prev_y <= VEL_ESTIMATOR_POSY_InBus;
                    r_prev_t <= VEL_ESTIMATOR_THETA_InBus;
                    r_primed <= 1'b1;
                end
            end
            if (w_diff) begin
                r_delta <= w_delta;
                r_acc   <= '0;
                r_bit   <= 3'd0;
            end
            // GAIN LSB first: add the delta magnitude shifted by the bit weight
            if (w_mult) begin
                if (C_GAIN[r_bit])
                    r_acc <= r_acc + (ACC_W'(r_delta[MAG_W-1:0]) << r_bit);
                r_bit <= r_bit + 3'd1;
            end
            if (w_store) begin
                case (r_axis)
                    2'd0:    r_stage_x <= {w_sign, w_mag};
                    2'd1:    r_stage_y <= {w_sign, w_mag};
                    default: r_stage_t <= {w_sign, w_mag};
                endcase
                r_axis <= r_axis + 2'd1;
            end
            if (w_done) begin
                r_vx     <= r_stage_x;
                r_vy     <= r_stage_y;
                r_wz     <= r_stage_t;
                r_valid  <= 1'b1;
                r_prev_x <= r_cur_x;
                r_prev_y <= r_cur_y;
                r_prev_t <= r_cur_t;
            end
        end
    end

    assign VEL_ESTIMATOR_VX_OutBus   = r_vx;
    assign VEL_ESTIMATOR_VY_OutBus   = r_vy;
    assign VEL_ESTIMATOR_WZ_OutBus   = r_wz;
    assign VEL_ESTIMATOR_VALID_Out   = r_valid;
    assign VEL_ESTIMATOR_OVERRUN_Out = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vel_estimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_vel_estimator -- directed vectors with queued expected results
// Revision : 1.0
// ============================================================================
module tb_vel_estimator;

    logic        clk = 1'b0;
    logic        rst_n, sb_a, sb_b;
    logic [16:0] px, py, pt;
    logic [16:0] vx_a, vy_a, wz_a, vx_b, vy_b, wz_b;
    logic        val_a, ov_a, val_b, ov_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mcnt     = 0;

    typedef struct {
        logic [16:0] vx;
        logic [16:0] vy;
        logic [16:0] wz;
        int          at;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [16:0] last_vx = '0, last_vy = '0, last_wz = '0;
    bit          sb_seen_low = 1'b1;

    always #10 clk = ~clk;

    vel_estimator #(.TICK_COUNT(64)) u_dut (
        .VEL_ESTIMATOR_CLOCK_50       (clk),
        .VEL_ESTIMATOR_RESET_InLow    (rst_n),
        .VEL_ESTIMATOR_SETBEGIN_InLow (sb_a),
        .VEL_ESTIMATOR_POSX_InBus     (px),
        .VEL_ESTIMATOR_POSY_InBus     (py),
        .VEL_ESTIMATOR_THETA_InBus    (pt),
        .VEL_ESTIMATOR_VX_OutBus      (vx_a),
        .VEL_ESTIMATOR_VY_OutBus      (vy_a),
        .VEL_ESTIMATOR_WZ_OutBus      (wz_a),
        .VEL_ESTIMATOR_VALID_Out      (val_a),
        .VEL_ESTIMATOR_OVERRUN_Out    (ov_a)
    );

    // Period shorter than one computation so a tick lands while busy
    vel_estimator #(.TICK_COUNT(20)) u_ovr (
        .VEL_ESTIMATOR_CLOCK_50       (clk),
        .VEL_ESTIMATOR_RESET_InLow    (rst_n),
        .VEL_ESTIMATOR_SETBEGIN_InLow (sb_b),
        .VEL_ESTIMATOR_POSX_InBus     (px),
        .VEL_ESTIMATOR_POSY_InBus     (py),
        .VEL_ESTIMATOR_THETA_InBus    (pt),
        .VEL_ESTIMATOR_VX_OutBus      (vx_b),
        .VEL_ESTIMATOR_VY_OutBus      (vy_b),
        .VEL_ESTIMATOR_WZ_OutBus      (wz_b),
        .VEL_ESTIMATOR_VALID_Out      (val_b),
        .VEL_ESTIMATOR_OVERRUN_Out    (ov_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference tick counter for the 64-clock instance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     mcnt <= 0;
        else if (!sb_a) mcnt <= 0;
        else            mcnt <= (mcnt == 63) ? 0 : mcnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_tick(output int t);
        t = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (mcnt == 63) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: no tick within 200 cycles");
        end
    endtask

    // Present a pose for the next tick; returns two cycles after the tick
    task automatic step(input logic [16:0] x, input logic [16:0] y, input logic [16:0] t,
                        input bit expect_valid, input logic [16:0] ex,
                        input logic [16:0] ey, input logic [16:0] et, output int tk);
        exp_t e;
        px = x; py = y; pt = t;
        wait_tick(tk);
        if (expect_valid && tk >= 0) begin
            e.vx = ex; e.vy = ey; e.wz = et; e.at = tk + 30;
            exp_q.push_back(e);
        end
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            last_vx = '0; last_vy = '0; last_wz = '0;
        end else begin
            if (sb_seen_low) begin
                last_vx = '0; last_vy = '0; last_wz = '0;
            end
            if (val_a) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: VALID high with nothing expected (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("vx", vx_a, mon_e.vx);
                    chk("vy", vy_a, mon_e.vy);
                    chk("wz", wz_a, mon_e.wz);
                    chk("valid_cycle", cyc, mon_e.at);
                end
                last_vx = vx_a; last_vy = vy_a; last_wz = wz_a;
            end else begin
                chk("outputs_held", {vx_a, vy_a, wz_a}, {last_vx, last_vy, last_wz});
            end
        end
        sb_seen_low = !sb_a;
    end

    initial begin
        int tk;
        rst_n = 1'b0; sb_a = 1'b0; sb_b = 1'b1;
        px = '0; py = '0; pt = '0;
        repeat (3) @(negedge clk);
        chk("reset_vx", vx_a, 17'h0);
        chk("reset_vy", vy_a, 17'h0);
        chk("reset_wz", wz_a, 17'h0);
        chk("reset_valid", val_a, 1'b0);
        chk("reset_overrun", ov_a, 1'b0);
        chk("reset_overrun_b", ov_b, 1'b0);
        rst_n = 1'b1;

        repeat (100) @(negedge clk);
        chk("overrun_set", ov_b, 1'b1);
        chk("overrun_a_quiet", ov_a, 1'b0);
        repeat (20) @(negedge clk);
        chk("overrun_sticky", ov_b, 1'b1);
        sb_b = 1'b0;
        @(negedge clk);
        chk("overrun_cleared", ov_b, 1'b0);

        sb_a = 1'b1;
        step(17'h00000, 17'h00000, 17'h00000, 0, 17'h0, 17'h0, 17'h0, tk);
        step(17'h00000, 17'h00000, 17'h00000, 1, 17'h0, 17'h0, 17'h0, tk);
        step(17'h00003, 17'h00000, 17'h00000, 1, 17'h0012C, 17'h0, 17'h0, tk);
        step(17'h00003, 17'h00100, 17'h00080, 1, 17'h0, 17'h06400, 17'h03200, tk);
        step(17'h00003, 17'h000FD, 17'h10080, 1, 17'h0, 17'h1012C, 17'h16400, tk);
        step(17'h00003, 17'h000FD, 17'h00080, 1, 17'h0, 17'h0, 17'h06400, tk);
        step(17'h00000, 17'h000FD, 17'h00080, 1, 17'h1012C, 17'h0, 17'h0, tk);
        step(17'h00300, 17'h000FD, 17'h00080, 1, 17'h0FFFF, 17'h0, 17'h0, tk);
        step(17'h08000, 17'h000FD, 17'h00080, 1, 17'h0FFFF, 17'h0, 17'h0, tk);
        step(17'h18000, 17'h000FD, 17'h00080, 1, 17'h1FFFF, 17'h0, 17'h0, tk);
        step(17'h10000, 17'h000FD, 17'h00080, 1, 17'h0FFFF, 17'h0, 17'h0, tk);
        step(17'h00000, 17'h000FD, 17'h00080, 1, 17'h0, 17'h0, 17'h0, tk);
        step(17'h00002, 17'h000FD, 17'h00080, 1, 17'h000C8, 17'h0, 17'h0, tk);

        // Clear during MULT of the X axis
        step(17'h00009, 17'h000FD, 17'h00080, 0, 17'h0, 17'h0, 17'h0, tk);
        repeat (3) @(negedge clk);
        sb_a = 1'b0;
        @(negedge clk);
        sb_a = 1'b1;
        chk("setbegin_vx", vx_a, 17'h0);
        chk("setbegin_vy", vy_a, 17'h0);
        chk("setbegin_wz", wz_a, 17'h0);
        chk("setbegin_valid", val_a, 1'b0);
        step(17'h00005, 17'h000FD, 17'h00080, 0, 17'h0, 17'h0, 17'h0, tk);
        step(17'h00006, 17'h000FD, 17'h00080, 1, 17'h00064, 17'h0, 17'h0, tk);

        // Asynchronous reset inside DONE
        step(17'h00007, 17'h000FD, 17'h00080, 0, 17'h0, 17'h0, 17'h0, tk);
        repeat (27) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_vx", vx_a, 17'h0);
        chk("async_vy", vy_a, 17'h0);
        chk("async_wz", wz_a, 17'h0);
        chk("async_valid", val_a, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(17'h00010, 17'h000FD, 17'h00080, 0, 17'h0, 17'h0, 17'h0, tk);
        step(17'h0000F, 17'h000FD, 17'h00080, 1, 17'h10064, 17'h0, 17'h0, tk);

        repeat (40) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("overrun_a_final", ov_a, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
